regbank_write_scheduler: RTL and testbench

- Shares the register bank's single write port between two write-back requesters: ALU result and memory load.
- Keeps a per-register pending scoreboard that stalls decode on write-after-write and exposes busy bits for hazard checks.
- Sequences the Halt drain. Sits between the execute/memory stages and the 8x8-bit register bank.

---
 rtl/regbank_write_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_regbank_write_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_write_scheduler.sv
// ============================================================================
//  Module   : regbank_write_scheduler
//  Purpose  : Arbitrates ALU / load write-back onto the single register-bank
//             write port, tracks outstanding writes, and sequences Halt drain.
//             Optional read-bypass: REGBANK_WRITE_SCHEDULER_BYPASS_EN
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regbank_write_scheduler #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int NREG       = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              Halt,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueReg,
    output logic              IssueReady,
    input  logic              AluValid,
    input  logic [ADDR_W-1:0] AluReg,
    input  logic [DATA_W-1:0] AluData,
    output logic              AluReady,
    input  logic              MemValid,
    input  logic [ADDR_W-1:0] MemReg,
    input  logic [DATA_W-1:0] MemData,
    output logic              MemReady,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] RegEscrito,
    output logic [DATA_W-1:0] DadoEscrito,
    output logic [NREG-1:0]   Pending,
`ifdef REGBANK_WRITE_SCHEDULER_BYPASS_EN
    input  logic [ADDR_W-1:0] ReadReg,
    output logic              FwdHit,
    output logic [DATA_W-1:0] FwdData,
`endif
    output logic              Halted
);

    localparam int c_STARVE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [NREG-1:0]       r_pending;
    logic [NREG-1:0]       w_pendingNext;
    logic [c_STARVE_W-1:0] r_starve;
    logic [c_STARVE_W-1:0] w_starveNext;
    logic                  r_halted;
    logic                  r_regWrite;
    logic [ADDR_W-1:0]     r_regEscrito;
    logic [DATA_W-1:0]     r_dadoEscrito;

    logic                  w_starveMax;
    logic                  w_aluGrant;
    logic                  w_memGrant;
    logic                  w_anyGrant;
    logic [ADDR_W-1:0]     w_winReg;
    logic [DATA_W-1:0]     w_winData;
    logic                  w_issueFire;

    assign w_starveMax = (r_starve == c_STARVE_W'(STARVE_MAX));

    // Loads win ties so memory latency stays bounded; ALU is rescued once starved.
    always_comb begin
        w_aluGrant = 1'b0;
        w_memGrant = 1'b0;
        if (ResetN && (r_state != ST_HALTED)) begin
            if (AluValid && MemValid) begin
                if (w_starveMax) begin
                    w_aluGrant = 1'b1;
                end else begin
                    w_memGrant = 1'b1;
                end
            end else if (AluValid) begin
                w_aluGrant = 1'b1;
            end else if (MemValid) begin
                w_memGrant = 1'b1;
            end
        end
    end

    assign w_anyGrant = w_aluGrant | w_memGrant;
    assign w_winReg   = w_aluGrant ? AluReg  : MemReg;
    assign w_winData  = w_aluGrant ? AluData : MemData;

    assign AluReady   = w_aluGrant;
    assign MemReady   = w_memGrant;
    assign IssueReady = ResetN && (r_state == ST_RUN) && !r_pending[IssueReg];
    assign w_issueFire = IssueValid && IssueReady;

    always_comb begin
        w_starveNext = r_starve;
        if (w_aluGrant) begin
            w_starveNext = '0;
        end else if (AluValid && !w_starveMax) begin
            w_starveNext = r_starve + c_STARVE_W'(1);
        end
    end

    // Set is applied after clear so a same-register issue keeps the bit set.
    always_comb begin
        w_pendingNext = r_pending;
        if (w_anyGrant) begin
            w_pendingNext[w_winReg] = 1'b0;
        end
        if (w_issueFire) begin
            w_pendingNext[IssueReg] = 1'b1;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_RUN: begin
                if (Halt) begin
                    w_stateNext = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((r_pending == '0) && !AluValid && !MemValid) begin
                    w_stateNext = ST_HALTED;
                end
            end
            ST_HALTED: begin
                w_stateNext = ST_HALTED;
            end
            default: begin
                w_stateNext = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state   <= ST_RUN;
            r_pending <= '0;
            r_starve  <= '0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_pending <= w_pendingNext;
            r_starve  <= w_starveNext;
            r_halted  <= (w_stateNext == ST_HALTED);
        end
    end

    // Address and data hold between writes; only the strobe is cleared.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_regWrite    <= 1'b0;
            r_regEscrito  <= '0;
            r_dadoEscrito <= '0;
        end else if (w_anyGrant) begin
            r_regWrite    <= 1'b1;
            r_regEscrito  <= w_winReg;
            r_dadoEscrito <= w_winData;
        end else begin
            r_regWrite    <= 1'b0;
        end
    end

    assign RegWrite    = r_regWrite;
    assign RegEscrito  = r_regEscrito;
    assign DadoEscrito = r_dadoEscrito;
    assign Pending     = r_pending;
    assign Halted      = r_halted;

`ifdef REGBANK_WRITE_SCHEDULER_BYPASS_EN
    assign FwdHit  = w_anyGrant && (w_winReg == ReadReg);
    assign FwdData = FwdHit ? w_winData : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regbank_write_scheduler.sv
// ============================================================================
//  Module   : tb_regbank_write_scheduler
//  Purpose  : Vector table plus write-back scoreboard for the write scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regbank_write_scheduler;

    logic       Clock;
    logic       ResetN;
    logic       Halt;
    logic       IssueValid;
    logic [2:0] IssueReg;
    logic       IssueReady;
    logic       AluValid;
    logic [2:0] AluReg;
    logic [7:0] AluData;
    logic       AluReady;
    logic       MemValid;
    logic [2:0] MemReg;
    logic [7:0] MemData;
    logic       MemReady;
    logic       RegWrite;
    logic [2:0] RegEscrito;
    logic [7:0] DadoEscrito;
    logic [7:0] Pending;
    logic       Halted;
`ifdef REGBANK_WRITE_SCHEDULER_BYPASS_EN
    logic [2:0] ReadReg;
    logic       FwdHit;
    logic [7:0] FwdData;
`endif

    regbank_write_scheduler dut (
        .Clock       (Clock),
        .ResetN      (ResetN),
        .Halt        (Halt),
        .IssueValid  (IssueValid),
        .IssueReg    (IssueReg),
        .IssueReady  (IssueReady),
        .AluValid    (AluValid),
        .AluReg      (AluReg),
        .AluData     (AluData),
        .AluReady    (AluReady),
        .MemValid    (MemValid),
        .MemReg      (MemReg),
        .MemData     (MemData),
        .MemReady    (MemReady),
        .RegWrite    (RegWrite),
        .RegEscrito  (RegEscrito),
        .DadoEscrito (DadoEscrito),
        .Pending     (Pending),
`ifdef REGBANK_WRITE_SCHEDULER_BYPASS_EN
        .ReadReg     (ReadReg),
        .FwdHit      (FwdHit),
        .FwdData     (FwdData),
`endif
        .Halted      (Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic       halt;
        logic       iv;
        logic [2:0] ireg;
        logic       av;
        logic [2:0] areg;
        logic [7:0] ad;
        logic       mv;
        logic [2:0] mreg;
        logic [7:0] md;
        logic       eIss;
        logic       eAlu;
        logic       eMem;
        logic [7:0] ePend;
        logic       eHalt;
    } vec_t;

    typedef struct {
        logic [2:0] r;
        logic [7:0] d;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb[$];
    int   nCmp = 0;
    int   nBad = 0;
    logic [2:0] lastReg  = '0;
    logic [7:0] lastData = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic halt, iv, input logic [2:0] ireg,
                                input logic av, input logic [2:0] areg, input logic [7:0] ad,
                                input logic mv, input logic [2:0] mreg, input logic [7:0] md,
                                input logic eIss, eAlu, eMem, input logic [7:0] ePend,
                                input logic eHalt);
        vec_t v;
        v.halt = halt; v.iv = iv; v.ireg = ireg;
        v.av = av; v.areg = areg; v.ad = ad;
        v.mv = mv; v.mreg = mreg; v.md = md;
        v.eIss = eIss; v.eAlu = eAlu; v.eMem = eMem; v.ePend = ePend; v.eHalt = eHalt;
        return v;
    endfunction

    task automatic idleInputs();
        Halt = 0; IssueValid = 0; IssueReg = 0;
        AluValid = 0; AluReg = 0; AluData = 0;
        MemValid = 0; MemReg = 0; MemData = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        //          halt iv ireg av areg ad     mv mreg md     iss alu mem pend   hlt
        vecs.push_back(mk(0, 1, 3, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 8'h08, 0));
        vecs.push_back(mk(0, 1, 3, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h08, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 8'hA5, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0));
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(0, 0, 0, 1, 1, 8'h11, 1, 2, 8'h22, 1,
                              (k % 4) == 3, (k % 4) != 3, 8'h00, 0));
        end
        vecs.push_back(mk(0, 1, 5, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 8'h20, 0));
        vecs.push_back(mk(0, 1, 6, 1, 5, 8'h55, 0, 0, 8'h00, 1, 1, 0, 8'h40, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 6, 8'h66, 1, 0, 1, 8'h00, 0));
        vecs.push_back(mk(0, 1, 7, 0, 0, 8'h00, 1, 7, 8'h77, 1, 0, 1, 8'h80, 0));
        vecs.push_back(mk(0, 0, 7, 0, 0, 8'h00, 1, 7, 8'h78, 0, 0, 1, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 8'h01, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 8'h03, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 8'hA0, 0, 0, 8'h00, 0, 1, 0, 8'h02, 0));
        vecs.push_back(mk(1, 1, 2, 0, 0, 8'h00, 1, 1, 8'hB1, 0, 0, 1, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 1, 4, 1, 4, 8'hC4, 1, 4, 8'hD4, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1));

        idleInputs();
`ifdef REGBANK_WRITE_SCHEDULER_BYPASS_EN
        ReadReg = 0;
`endif
        ResetN = 0;
        AluValid = 1; MemValid = 1;
        #12;
        chk("reset AluReady", AluReady, 0);
        chk("reset MemReady", MemReady, 0);
        chk("reset IssueReady", IssueReady, 0);
        chk("reset RegWrite", RegWrite, 0);
        chk("reset RegEscrito", RegEscrito, 0);
        chk("reset DadoEscrito", DadoEscrito, 0);
        chk("reset Pending", Pending, 0);
        chk("reset Halted", Halted, 0);
        idleInputs();
        ResetN = 1;
        @(posedge Clock); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            wr_t  w;
            v = vecs[i];
            Halt = v.halt; IssueValid = v.iv; IssueReg = v.ireg;
            AluValid = v.av; AluReg = v.areg; AluData = v.ad;
            MemValid = v.mv; MemReg = v.mreg; MemData = v.md;
            @(negedge Clock);
            chk($sformatf("v%0d IssueReady", i), IssueReady, v.eIss);
            chk($sformatf("v%0d AluReady", i), AluReady, v.eAlu);
            chk($sformatf("v%0d MemReady", i), MemReady, v.eMem);
            if (v.eAlu) begin w.r = v.areg; w.d = v.ad; sb.push_back(w); end
            if (v.eMem) begin w.r = v.mreg; w.d = v.md; sb.push_back(w); end
            @(posedge Clock); #1;
            if (sb.size() > 0) begin
                w = sb.pop_front();
                chk($sformatf("v%0d RegWrite", i), RegWrite, 1);
                chk($sformatf("v%0d RegEscrito", i), RegEscrito, w.r);
                chk($sformatf("v%0d DadoEscrito", i), DadoEscrito, w.d);
                lastReg = w.r; lastData = w.d;
            end else begin
                chk($sformatf("v%0d RegWrite", i), RegWrite, 0);
                chk($sformatf("v%0d RegEscrito hold", i), RegEscrito, lastReg);
                chk($sformatf("v%0d DadoEscrito hold", i), DadoEscrito, lastData);
            end
            chk($sformatf("v%0d Pending", i), Pending, v.ePend);
            chk($sformatf("v%0d Halted", i), Halted, v.eHalt);
        end

        // Asynchronous reset out of HALTED, no clock edge involved.
        idleInputs();
        AluValid = 1;
        ResetN = 0;
        #1;
        chk("rst halted Halted", Halted, 0);
        chk("rst halted AluReady", AluReady, 0);
        #2;
        AluValid = 0;
        ResetN = 1;
        @(posedge Clock); #1;

        // Reset while a write strobe is active.
        IssueValid = 1; IssueReg = 3;
        @(posedge Clock); #1;
        IssueValid = 0;
        AluValid = 1; AluReg = 2; AluData = 8'h5A;
        @(posedge Clock); #1;
        AluValid = 0;
        chk("midwrite RegWrite before", RegWrite, 1);
        chk("midwrite Pending before", Pending, 8'h08);
        #1;
        ResetN = 0;
        #1;
        chk("midwrite RegWrite", RegWrite, 0);
        chk("midwrite Pending", Pending, 0);
        chk("midwrite RegEscrito", RegEscrito, 0);
        chk("midwrite DadoEscrito", DadoEscrito, 0);
        ResetN = 1;
        @(posedge Clock); #1;

`ifdef REGBANK_WRITE_SCHEDULER_BYPASS_EN
        ReadReg = 4;
        MemValid = 1; MemReg = 4; MemData = 8'h3C;
        #1;
        chk("fwd hit FwdHit", FwdHit, 1);
        chk("fwd hit FwdData", FwdData, 8'h3C);
        ReadReg = 5;
        #1;
        chk("fwd miss FwdHit", FwdHit, 0);
        chk("fwd miss FwdData", FwdData, 0);
        @(posedge Clock); #1;
        MemValid = 0;
        chk("fwd RegWrite", RegWrite, 1);
        chk("fwd DadoEscrito", DadoEscrito, 8'h3C);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

`default_nettype wire
